// File: rtl/ysyx_22040365_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040365_mc_core
// Brief    : Multi-cycle RV subset core (ADDI/ADD/SUB/LUI/AUIPC/JAL/JALR/EBREAK)
//            with fetch handshake, 32-entry regfile and EBREAK halt/exit code.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040365_mc_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h80000000),
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             illegal,
  output logic [XLEN-1:0]  halt_code
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [6:0]  c_op_imm    = 7'b0010011;
  localparam logic [6:0]  c_op_reg    = 7'b0110011;
  localparam logic [6:0]  c_op_lui    = 7'b0110111;
  localparam logic [6:0]  c_op_auipc  = 7'b0010111;
  localparam logic [6:0]  c_op_jal    = 7'b1101111;
  localparam logic [6:0]  c_op_jalr   = 7'b1100111;
  localparam logic [31:0] c_ebreak    = 32'h0010_0073;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_regs [0:31];
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic [CNT_W-1:0]  r_instret;
  logic              r_halted;
  logic              r_illegal;
  logic [XLEN-1:0]   r_halt_code;

  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_u;
  logic [XLEN-1:0]   w_imm_j;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   w_next_pc;
  logic [4:0]        w_rd;
  logic              w_legal;
  logic              w_ebreak;
  logic              w_fault;

  // x0 is never written after reset, so reading index 0 always yields zero
  assign w_rs1_val  = r_regs[r_ir[19:15]];
  assign w_rs2_val  = r_regs[r_ir[24:20]];
  assign w_imm_i    = XLEN'($signed(r_ir[31:20]));
  assign w_imm_u    = XLEN'($signed({r_ir[31:12], 12'b0}));
  assign w_imm_j    = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
  assign w_pc_plus4 = r_pc + XLEN'(4);

  always_comb begin
    w_result  = '0;
    w_next_pc = w_pc_plus4;
    w_rd      = r_ir[11:7];
    w_legal   = 1'b0;
    w_ebreak  = 1'b0;
    case (r_ir[6:0])
      c_op_imm: begin
        w_legal  = (r_ir[14:12] == 3'b000);
        w_result = w_rs1_val + w_imm_i;
      end
      c_op_reg: begin
        if (r_ir[14:12] == 3'b000 && r_ir[31:25] == 7'b0000000) begin
          w_legal  = 1'b1;
          w_result = w_rs1_val + w_rs2_val;
        end else if (r_ir[14:12] == 3'b000 && r_ir[31:25] == 7'b0100000) begin
          w_legal  = 1'b1;
          w_result = w_rs1_val - w_rs2_val;
        end
      end
      c_op_lui: begin
        w_legal  = 1'b1;
        w_result = w_imm_u;
      end
      c_op_auipc: begin
        w_legal  = 1'b1;
        w_result = r_pc + w_imm_u;
      end
      c_op_jal: begin
        w_legal   = 1'b1;
        w_result  = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      c_op_jalr: begin
        w_legal   = (r_ir[14:12] == 3'b000);
        w_result  = w_pc_plus4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~XLEN'(1);
      end
      default: begin
        if (r_ir == c_ebreak) begin
          w_legal  = 1'b1;
          w_ebreak = 1'b1;
          w_rd     = 5'd0;
        end
      end
    endcase
  end

  // A target with bit1 set cannot be fetched as a 32-bit word; treat as a fault
  assign w_fault = !w_legal || w_next_pc[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (imem_valid) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = w_fault ? S_HALT : S_WB;
      S_WB:    w_state_nxt = r_halted ? S_HALT : S_FETCH;
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Retirement side effects are registered on the EXEC->WB edge so the
  // WB cycle presents the pulse together with the updated counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_instret   <= '0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_halt_code <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        S_FETCH: if (imem_valid) r_ir <= imem_rdata;
        S_EXEC: begin
          if (w_fault) begin
            r_halted  <= 1'b1;
            r_illegal <= 1'b1;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= w_rd;
            r_wb_data  <= w_result;
            r_instret  <= r_instret + CNT_W'(1);
            r_pc       <= w_next_pc;
            if (w_rd != 5'd0) r_regs[w_rd] <= w_result;
            if (w_ebreak) begin
              r_halted    <= 1'b1;
              r_halt_code <= r_regs[10];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = rst_n && (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign instret   = r_instret;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign halt_code = r_halt_code;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040365_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040365_mc_core
// Brief    : Scoreboard bench for the multi-cycle core, XLEN=64 and XLEN=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040365_mc_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req,   imem_req32;
  logic [63:0] imem_addr;
  logic [31:0] imem_addr32;
  logic        wb_valid,   wb_valid32;
  logic [4:0]  wb_rd,      wb_rd32;
  logic [63:0] wb_data;
  logic [31:0] wb_data32;
  logic [31:0] instret,    instret32;
  logic        halted,     halted32;
  logic        illegal,    illegal32;
  logic [63:0] halt_code;
  logic [31:0] halt_code32;

  ysyx_22040365_mc_core #(.XLEN(64), .RESET_PC(64'h8000_0000), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .instret(instret), .halted(halted),
    .illegal(illegal), .halt_code(halt_code)
  );

  ysyx_22040365_mc_core #(.XLEN(32), .RESET_PC(32'h8000_0000), .CNT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req32), .imem_addr(imem_addr32),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .wb_valid(wb_valid32),
    .wb_rd(wb_rd32), .wb_data(wb_data32), .instret(instret32), .halted(halted32),
    .illegal(illegal32), .halt_code(halt_code32)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk_data;
    int          inst;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   last_drive = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every retirement pops one expectation; both widths must agree
  always @(negedge clk) begin
    if (rst_n && (wb_valid || wb_valid32)) begin
      check("wb_valid32_match", {63'd0, wb_valid32}, {63'd0, wb_valid});
      if (wb_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: got rd=%0d data=%h, expected no retire", wb_rd, wb_data);
        end else begin
          e = sb.pop_front();
          check("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
          if (e.chk_data) begin
            check("wb_data", wb_data, e.data);
            check("wb_data32", {32'd0, wb_data32}, {32'd0, e.data[31:0]});
          end
          check("instret", {32'd0, instret}, 64'(e.inst));
          check("instret32", {32'd0, instret32}, 64'(e.inst));
          check("retire_latency", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  task automatic fetch(input logic [63:0] addr, input logic [31:0] instr, input bit retire,
                       input logic [4:0] rd, input logic [63:0] data, input bit chk_data,
                       input int inst, input int stall, input bit chk_lat);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got imem_req=0 for %0d cycles, expected 1", n);
      return;
    end
    if (chk_lat) check("req_latency", 64'(cyc), 64'(last_drive + 3));
    check("imem_addr", imem_addr, addr);
    check("imem_addr32", {32'd0, imem_addr32}, {32'd0, addr[31:0]});
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_req", {63'd0, imem_req}, 64'd1);
      check("stall_addr", imem_addr, addr);
      check("stall_instret", {32'd0, instret}, 64'(inst - 1));
    end
    if (retire) sb.push_back('{rd: rd, data: data, chk_data: chk_data, inst: inst, at: cyc + 2});
    imem_valid = 1'b1;
    imem_rdata = instr;
    last_drive = cyc;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic check_halt(input int cycles, input bit exp_ill, input logic [63:0] code,
                            input int inst, input bit spurious);
    if (spurious) begin
      imem_valid = 1'b1;
      imem_rdata = 32'h0050_0093;
    end
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("halt_req", {63'd0, imem_req}, 64'd0);
    end
    imem_valid = 1'b0;
    imem_rdata = '0;
    check("halted", {63'd0, halted}, 64'd1);
    check("halted32", {63'd0, halted32}, 64'd1);
    check("illegal", {63'd0, illegal}, {63'd0, exp_ill});
    check("illegal32", {63'd0, illegal32}, {63'd0, exp_ill});
    check("halt_code", halt_code, code);
    check("halt_code32", {32'd0, halt_code32}, {32'd0, code[31:0]});
    check("halt_instret", {32'd0, instret}, 64'(inst));
  endtask

  task automatic do_reset();
    check("pending_retire", 64'(sb.size()), 64'd0);
    rst_n = 1'b0;
    imem_valid = 1'b0;
    #1;
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_req32", {63'd0, imem_req32}, 64'd0);
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_instret", {32'd0, instret}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    check("rst_halt_code", halt_code, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req", {63'd0, imem_req}, 64'd1);
    check("rel_addr", imem_addr, 64'h8000_0000);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Run 1: arithmetic, x0 handling, fetch stall, LUI/AUIPC, EBREAK exit
    do_reset();
    fetch(64'h8000_0000, 32'h0050_0093, 1, 5'd1,  64'd5,                 1, 1, 0, 0);
    fetch(64'h8000_0004, 32'h0070_0013, 1, 5'd0,  64'd7,                 1, 2, 0, 1);
    fetch(64'h8000_0008, 32'h0000_0133, 1, 5'd2,  64'd0,                 1, 3, 0, 1);
    fetch(64'h8000_000C, 32'h02A0_0513, 1, 5'd10, 64'd42,                1, 4, 5, 0);
    fetch(64'h8000_0010, 32'h4015_01B3, 1, 5'd3,  64'd37,                1, 5, 0, 1);
    fetch(64'h8000_0014, 32'hFFFF_F237, 1, 5'd4,  64'hFFFF_FFFF_FFFF_F000, 1, 6, 0, 1);
    fetch(64'h8000_0018, 32'h0000_1317, 1, 5'd6,  64'h8000_1018,         1, 7, 0, 1);
    fetch(64'h8000_001C, 32'h0010_0073, 1, 5'd0,  64'd0,                 0, 8, 0, 1);
    check_halt(12, 0, 64'd42, 8, 1);

    // Run 2: JAL, aligned JALR, then JALR to a target with bit1 set
    do_reset();
    fetch(64'h8000_0000, 32'h0080_00EF, 1, 5'd1, 64'h8000_0004, 1, 1, 0, 0);
    fetch(64'h8000_0008, 32'h0040_8067, 1, 5'd0, 64'h8000_000C, 1, 2, 0, 1);
    fetch(64'h8000_0008, 32'h0020_82E7, 0, 5'd0, 64'd0,        0, 2, 0, 1);
    check_halt(10, 1, 64'd0, 2, 0);

    // Run 3: illegal encoding, reset out of HALT, reset mid-FETCH
    do_reset();
    fetch(64'h8000_0000, 32'hFFFF_FFFF, 0, 5'd0, 64'd0, 0, 0, 0, 0);
    check_halt(10, 1, 64'd0, 0, 0);
    do_reset();
    fetch(64'h8000_0000, 32'h0050_0093, 1, 5'd1, 64'd5, 1, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("refetch_req", {63'd0, imem_req}, 64'd1);
    check("refetch_addr", imem_addr, 64'h8000_0004);
    do_reset();
    fetch(64'h8000_0000, 32'h02A0_0513, 1, 5'd10, 64'd42, 1, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("final_pending", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
